// File: rtl/sram_uart_dumper_pkg.sv
// Shared constants and state encoding for the SRAM-to-UART read-back dumper.
package sram_uart_dumper_pkg;

  localparam int          DEF_ADDR_W     = 5;
  localparam int          BYTES_PER_WORD = 4;
  localparam int          DEF_DATA_W     = 8 * BYTES_PER_WORD;
  localparam int          DEF_NUM_WORDS  = 32;
  localparam logic [7:0]  DEF_SYNC_BYTE  = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SYNC  = 3'd1,
    ST_FETCH = 3'd2,
    ST_CAPT  = 3'd3,
    ST_SEND  = 3'd4,
    ST_CSUM  = 3'd5,
    ST_DONE  = 3'd6
  } state_t;

  // Byte-index width that stays legal when a word holds a single byte.
  function automatic int idx_width(input int bpw);
    return (bpw > 1) ? $clog2(bpw) : 1;
  endfunction

endpackage

// File: rtl/sram_uart_dumper.sv
// Reads NUM_WORDS SRAM words and streams them to the UART transmitter as
// SYNC_BYTE, data bytes (LSB first per word), then an 8-bit additive checksum.
module sram_uart_dumper
  import sram_uart_dumper_pkg::*;
#(
  parameter int         ADDR_W    = DEF_ADDR_W,
  parameter int         DATA_W    = DEF_DATA_W,
  parameter int         NUM_WORDS = DEF_NUM_WORDS,
  parameter logic [7:0] SYNC_BYTE = DEF_SYNC_BYTE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic              csb_n,
  output logic              we_n,
  output logic [3:0]        wmask,
  output logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] sram_data_out,
  input  logic              tx_ready,
  output logic              tx_enable,
  output logic              tx_valid,
  output logic [7:0]        tx_data_in
);

  localparam int                BPW       = DATA_W / 8;
  localparam int                IDX_W     = idx_width(BPW);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(BPW - 1);
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(NUM_WORDS - 1);

  state_t              state;
  state_t              state_next;
  logic [ADDR_W-1:0]   counter;
  logic [IDX_W-1:0]    idx;
  logic [DATA_W-1:0]   word_q;
  logic [7:0]          csum;
  logic                armed;
  logic [DATA_W-1:0]   word_shifted;
  logic [7:0]          cur_byte;

  assign word_shifted = word_q >> {idx, 3'b000};
  assign cur_byte     = word_shifted[7:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (start && armed) state_next = ST_SYNC;
      ST_SYNC:  if (tx_ready)       state_next = ST_FETCH;
      ST_FETCH: if (mem_gnt)        state_next = ST_CAPT;
      ST_CAPT:                      state_next = ST_SEND;
      ST_SEND: begin
        if (tx_ready && idx == LAST_IDX)
          state_next = (counter == LAST_WORD) ? ST_CSUM : ST_FETCH;
      end
      ST_CSUM:  if (tx_ready)       state_next = ST_DONE;
      ST_DONE:                      state_next = ST_IDLE;
      default:                      state_next = ST_IDLE;
    endcase
  end

  // armed blocks a start sampled on the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      counter <= '0;
      idx     <= '0;
      word_q  <= '0;
      csum    <= '0;
      armed   <= 1'b0;
    end else begin
      armed <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (start && armed) begin
            counter <= '0;
            csum    <= '0;
          end
        end
        ST_CAPT: begin
          word_q <= sram_data_out;
          idx    <= '0;
        end
        ST_SEND: begin
          if (tx_ready) begin
            csum <= csum + cur_byte;
            if (idx != LAST_IDX)
              idx <= idx + 1'b1;
            else if (counter != LAST_WORD)
              counter <= counter + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy       = 1'b0;
    done       = 1'b0;
    mem_req    = 1'b0;
    csb_n      = 1'b1;
    tx_valid   = 1'b0;
    tx_data_in = 8'h00;
    case (state)
      ST_SYNC: begin
        busy       = 1'b1;
        tx_valid   = 1'b1;
        tx_data_in = SYNC_BYTE;
      end
      ST_FETCH: begin
        busy    = 1'b1;
        mem_req = 1'b1;
        csb_n   = ~mem_gnt;
      end
      ST_CAPT: begin
        busy    = 1'b1;
        mem_req = 1'b1;
      end
      ST_SEND: begin
        busy       = 1'b1;
        tx_valid   = 1'b1;
        tx_data_in = cur_byte;
      end
      ST_CSUM: begin
        busy       = 1'b1;
        tx_valid   = 1'b1;
        tx_data_in = csum;
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  assign tx_enable = busy;
  assign we_n      = 1'b1;
  assign wmask     = 4'b0000;
  assign addr      = counter;

endmodule
